// File: rtl/systolic_pkg.sv
// Shared defaults and FSM state type for the systolic result path.
package systolic_pkg;

    localparam int DEFAULT_N          = 3;
    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DONE   = 2'd3
    } stream_state_t;

endpackage

// File: rtl/stream_fifo.sv
// Small power-of-two FIFO; head is visible on pop_dat_o while not empty.
// Push into a full FIFO is accepted only together with a pop.
module stream_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_dat_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       pop_dat_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty_o   = (r_count == '0);
    assign full_o    = (r_count == (PW+1)'(DEPTH));
    assign count_o   = r_count;
    assign pop_dat_o = r_mem[r_rd_ptr];
    assign w_do_pop  = pop_i & ~empty_o;
    assign w_do_push = push_i & (~full_o | w_do_pop);

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_dat_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/output_streamer.sv
// Streams the result SRAM out in address order on a valid/ready port.
// First element 3 cycles after the trigger edge; reads are credit-limited to FIFO_DEPTH.
module output_streamer
    import systolic_pkg::*;
#(
    parameter int N          = DEFAULT_N,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int SRAM_DEPTH = N * N,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          collection_complete_i,
    output logic                          sram_read_enable_o,
    output logic [$clog2(SRAM_DEPTH)-1:0] sram_read_addr_o,
    input  logic [DATA_WIDTH-1:0]         sram_read_data_i,
    input  logic                          sram_read_valid_i,
    output logic [DATA_WIDTH-1:0]         m_data_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic                          m_last_o,
    output logic                          busy_o,
    output logic                          done_o
);
    localparam int AW = $clog2(SRAM_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(SRAM_DEPTH - 1);

    stream_state_t     r_state;
    stream_state_t     w_state_nxt;
    logic              r_cc_q;
    logic [AW-1:0]     r_addr;
    logic [CW-1:0]     r_outstanding;
    logic              r_last_issued;
    logic              w_cc_rise;
    logic              w_rd_en;
    logic              w_push;
    logic              w_push_last;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic [CW:0]       w_used;
    logic [DATA_WIDTH:0] w_head;

    assign w_cc_rise   = collection_complete_i & ~r_cc_q;
    assign w_pop       = ~w_empty & m_ready_i;
    assign w_push      = sram_read_valid_i & (r_outstanding != '0);
    // Reads return in order, so the final outstanding read after the last issue is the tail.
    assign w_push_last = r_last_issued & (r_outstanding == CW'(1));
    assign w_used      = {1'b0, w_count} + {1'b0, r_outstanding} - (CW+1)'(w_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_cc_rise) w_state_nxt = ST_STREAM;
            ST_STREAM: if (w_rd_en && (r_addr == LAST_ADDR)) w_state_nxt = ST_FLUSH;
            ST_FLUSH:  if (w_pop && w_head[DATA_WIDTH]) w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rd_en = (r_state == ST_STREAM) && (w_used < (CW+1)'(FIFO_DEPTH));
        busy_o  = (r_state == ST_STREAM) || (r_state == ST_FLUSH);
        done_o  = (r_state == ST_DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cc_q        <= 1'b0;
            r_addr        <= '0;
            r_outstanding <= '0;
            r_last_issued <= 1'b0;
        end else begin
            r_cc_q <= collection_complete_i;
            if ((r_state == ST_IDLE) && w_cc_rise) begin
                r_addr        <= '0;
                r_last_issued <= 1'b0;
            end else if (w_rd_en) begin
                if (r_addr == LAST_ADDR) begin
                    r_last_issued <= 1'b1;
                end else begin
                    r_addr <= r_addr + AW'(1);
                end
            end
            unique case ({w_rd_en, w_push})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    stream_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (w_push),
        .push_dat_i ({w_push_last, sram_read_data_i}),
        .pop_i      (w_pop),
        .pop_dat_o  (w_head),
        .full_o     (w_full),
        .empty_o    (w_empty),
        .count_o    (w_count)
    );

    assign sram_read_enable_o = w_rd_en;
    assign sram_read_addr_o   = r_addr;
    assign m_valid_o          = ~w_empty;
    assign m_data_o           = w_empty ? '0 : w_head[DATA_WIDTH-1:0];
    assign m_last_o           = ~w_empty & w_head[DATA_WIDTH];

endmodule

// File: tb/tb_output_streamer.sv
// Directed bench for output_streamer: N=3 passes under various ready patterns, reset, and an N=4 pass.
module tb_output_streamer;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          cc3, en3, valid3, rdy3, last3, busy3, done3;
    logic          rv3 = 1'b0;
    logic [3:0]    addr3;
    logic [DW-1:0] rd3 = '0;
    logic [DW-1:0] dat3;
    logic          cc4, en4, valid4, rdy4, last4, busy4, done4;
    logic          rv4 = 1'b0;
    logic [3:0]    addr4;
    logic [DW-1:0] rd4 = '0;
    logic [DW-1:0] dat4;
    logic [DW-1:0] mem3 [16];
    logic [DW-1:0] mem4 [16];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int t0    = 0;

    logic [DW-1:0] q_dat[$];
    logic          q_last[$];
    int            q_cyc[$];
    int            n_reads   = 0;
    int            n_done    = 0;
    int            done_cyc  = 0;
    int            infl_base = 0;
    int            max_infl  = 0;
    int            stab_viol = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_dat   = '0;
    logic          prev_last  = 1'b0;
    logic [DW-1:0] q4_dat[$];
    logic          q4_last[$];
    int            n4_done = 0;

    output_streamer #(.N(3)) u_dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .collection_complete_i (cc3),
        .sram_read_enable_o    (en3),
        .sram_read_addr_o      (addr3),
        .sram_read_data_i      (rd3),
        .sram_read_valid_i     (rv3),
        .m_data_o              (dat3),
        .m_valid_o             (valid3),
        .m_ready_i             (rdy3),
        .m_last_o              (last3),
        .busy_o                (busy3),
        .done_o                (done3)
    );

    output_streamer #(.N(4)) u_dut4 (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .collection_complete_i (cc4),
        .sram_read_enable_o    (en4),
        .sram_read_addr_o      (addr4),
        .sram_read_data_i      (rd4),
        .sram_read_valid_i     (rv4),
        .m_data_o              (dat4),
        .m_valid_o             (valid4),
        .m_ready_i             (rdy4),
        .m_last_o              (last4),
        .busy_o                (busy4),
        .done_o                (done4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM models: data and valid one cycle after the request.
    always @(posedge clk) begin
        rv3 <= en3;
        rd3 <= mem3[addr3];
        rv4 <= en4;
        rd4 <= mem4[addr4];
    end

    always @(negedge clk) begin
        if (rst) begin
            infl_base  = n_reads - q_dat.size();
            prev_stall = 1'b0;
        end else begin
            if (en3) n_reads++;
            if (valid3 && rdy3) begin
                q_dat.push_back(dat3);
                q_last.push_back(last3);
                q_cyc.push_back(cyc);
            end
            if (prev_stall && (!valid3 || dat3 !== prev_dat || last3 !== prev_last)) stab_viol++;
            prev_stall = valid3 && !rdy3;
            prev_dat   = dat3;
            prev_last  = last3;
            if (done3) begin
                n_done++;
                done_cyc = cyc;
            end
            if (n_reads - q_dat.size() - infl_base > max_infl) max_infl = n_reads - q_dat.size() - infl_base;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (valid4 && rdy4) begin
                q4_dat.push_back(dat4);
                q4_last.push_back(last4);
            end
            if (done4) n4_done++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_en"},    64'(en3),    0);
        chk({tag, "_addr"},  64'(addr3),  0);
        chk({tag, "_valid"}, 64'(valid3), 0);
        chk({tag, "_data"},  64'(dat3),   0);
        chk({tag, "_last"},  64'(last3),  0);
        chk({tag, "_busy"},  64'(busy3),  0);
        chk({tag, "_done"},  64'(done3),  0);
    endtask

    task automatic pulse3();
        @(posedge clk); #1;
        cc3 = 1'b1;
        t0  = cyc;
        @(posedge clk); #1;
        cc3 = 1'b0;
    endtask

    task automatic wait_done3(input int base, input string tag, input bit rand_rdy);
        int k = 0;
        while (n_done == base && k < 400) begin
            @(posedge clk); #1;
            if (rand_rdy) rdy3 = 1'($urandom % 2);
            k++;
        end
        chk({tag, "_done_seen"}, 64'(n_done - base), 1);
        rdy3 = 1'b1;
    endtask

    task automatic check_pass3(input string tag, input int b);
        chk({tag, "_count"}, 64'(q_dat.size() - b), 9);
        for (int i = 0; i < 9; i++) begin
            if (b + i < q_dat.size()) begin
                chk($sformatf("%s_dat%0d", tag, i), 64'(q_dat[b+i]), 64'(i));
                chk($sformatf("%s_last%0d", tag, i), 64'(q_last[b+i]), 64'(i == 8));
            end
        end
    endtask

    initial begin
        int b;
        int d;
        int r0;
        int k;
        for (int i = 0; i < 16; i++) begin
            mem3[i] = 32'(i);
            mem4[i] = 32'(100 + i);
        end
        rst  = 1'b1;
        cc3  = 1'b0;
        rdy3 = 1'b1;
        cc4  = 1'b0;
        rdy4 = 1'b1;
        #1;
        chk_quiet("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Full pass, consumer always ready.
        b = q_dat.size();
        d = n_done;
        pulse3();
        wait_done3(d, "t1", 1'b0);
        check_pass3("t1", b);
        if (q_cyc.size() >= b + 9) begin
            chk("t1_first_latency", 64'(q_cyc[b] - t0), 3);
            chk("t1_back_to_back", 64'(q_cyc[b+8] - q_cyc[b]), 8);
            chk("t1_done_after_last", 64'(done_cyc - q_cyc[b+8]), 1);
        end
        repeat (3) @(posedge clk);

        // Random 50% backpressure.
        b = q_dat.size();
        d = n_done;
        pulse3();
        wait_done3(d, "t2", 1'b1);
        check_pass3("t2", b);
        repeat (3) @(posedge clk);

        // Consumer stalled for 10 cycles after the trigger.
        b  = q_dat.size();
        d  = n_done;
        r0 = n_reads;
        rdy3 = 1'b0;
        pulse3();
        repeat (9) @(posedge clk);
        #1;
        chk("t3_reads_while_stalled", 64'(n_reads - r0), 2);
        chk("t3_valid_while_stalled", 64'(valid3), 1);
        chk("t3_head_while_stalled", 64'(dat3), 0);
        rdy3 = 1'b1;
        wait_done3(d, "t3", 1'b0);
        check_pass3("t3", b);
        repeat (3) @(posedge clk);

        // Level held high must trigger exactly one pass.
        b = q_dat.size();
        d = n_done;
        @(posedge clk); #1;
        cc3 = 1'b1;
        repeat (30) @(posedge clk);
        #1 cc3 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("t4_done_count", 64'(n_done - d), 1);
        check_pass3("t4", b);

        // Reset after 4 transfers, then a clean pass.
        b = q_dat.size();
        pulse3();
        k = 0;
        while (q_dat.size() - b < 4 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t5_four_xfers", 64'(q_dat.size() - b), 4);
        #2 rst = 1'b1;
        #1;
        chk_quiet("t5_midreset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        b = q_dat.size();
        d = n_done;
        pulse3();
        wait_done3(d, "t5", 1'b0);
        check_pass3("t5", b);

        chk("stall_stability", 64'(stab_viol), 0);
        chk("max_inflight", 64'(max_infl), 2);

        // N=4 instance: 16 elements, last only on address 15.
        @(posedge clk); #1;
        cc4 = 1'b1;
        @(posedge clk); #1;
        cc4 = 1'b0;
        k = 0;
        while (n4_done == 0 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("n4_done_seen", 64'(n4_done), 1);
        chk("n4_count", 64'(q4_dat.size()), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < q4_dat.size()) begin
                chk($sformatf("n4_dat%0d", i), 64'(q4_dat[i]), 64'(100 + i));
                chk($sformatf("n4_last%0d", i), 64'(q4_last[i]), 64'(i == 15));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
